// File: rtl/ascon_pack.sv
// -----------------------------------------------------------------------------
// ascon_pack
// Shared types and constants for the Ascon-128 permutation control path.
//   type_perm_mode : permutation phase requested by the mode controller
//   type_seq_state : state of the permutation sequencer FSM
//   NB_ROUNDS_A/B  : default round counts for p^a and p^b
//   LAST_ROUND     : round-constant index of the final round (always 11)
// -----------------------------------------------------------------------------
package ascon_pack;

    typedef enum logic [1:0] {
        MODE_INIT,
        MODE_DATA,
        MODE_FINAL,
        MODE_RSVD
    } type_perm_mode;

    typedef enum {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } type_seq_state;

    localparam int          NB_ROUNDS_A = 12;
    localparam int          NB_ROUNDS_B = 6;
    localparam logic [3:0]  LAST_ROUND  = 4'hB;

    // Ascon always ends on round constant 11, so an N-round call starts at 12-N.
    function automatic logic [3:0] start_index(input int nb_rounds);
        return 4'(12 - nb_rounds);
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// -----------------------------------------------------------------------------
// ascon_round_counter
// 4-bit loadable up-counter producing the round-constant index.
//   clock_i      : clock
//   reset_i      : synchronous active-high reset (count and start index to 0)
//   load_i       : load start_idx_i into the counter and remember it
//   start_idx_i  : first round index of the call
//   enable_i     : increment count by one
//   count_o      : current round index
//   first_o      : count equals the remembered start index
//   last_o       : count equals LAST_ROUND
// -----------------------------------------------------------------------------
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [3:0] start_idx_i,
    input  logic       enable_i,
    output logic [3:0] count_o,
    output logic       first_o,
    output logic       last_o
);

    logic [3:0] count_q;
    logic [3:0] start_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= 4'h0;
            start_q <= 4'h0;
        end else if (load_i) begin
            count_q <= start_idx_i;
            start_q <= start_idx_i;
        end else if (enable_i) begin
            count_q <= count_q + 4'h1;
        end
    end

    assign count_o = count_q;
    assign first_o = (count_q == start_q);
    assign last_o  = (count_q == LAST_ROUND);

endmodule

// File: rtl/ascon_perm_sequencer.sv
// -----------------------------------------------------------------------------
// ascon_perm_sequencer
// Control FSM sequencing one Ascon permutation call (p^a for INIT/FINAL,
// p^b for DATA) on the permutation_inter datapath.
//   clock_i, reset_i   : clock, synchronous active-high reset
//   start_i            : start request, sampled only while ready_o=1
//   mode_i             : 00 INIT, 01 DATA, 10 FINAL, 11 reserved (ignored)
//   last_blk_i         : DATA only, last AD block -> domain-separation bit
//   ready_o            : idle, a start will be accepted
//   round_o            : round-constant index for the datapath
//   data_sel_o         : 0 = external state_i, 1 = state register feedback
//   en_reg_state_o     : state register write enable
//   en_xor_data_o      : XOR data block into x0 at first-round input
//   en_xor_key_o       : XOR key into x1..x2 at first-round input
//   en_xor_key_end_o   : XOR key into x3..x4 at last-round output
//   en_xor_lsb_o       : XOR 1 into LSB of x4 at last-round output
//   done_o             : one-cycle pulse, result valid in state register
// All outputs are decoded from registered state only (Moore).
// -----------------------------------------------------------------------------
module ascon_perm_sequencer
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = NB_ROUNDS_A,
    parameter int ROUNDS_B = NB_ROUNDS_B
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  logic       last_blk_i,
    output logic       ready_o,
    output logic [3:0] round_o,
    output logic       data_sel_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       done_o
);

    // A round count outside 1..12 would push the 4-bit counter past 4'hB.
    if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
        $error("ascon_perm_sequencer: ROUNDS_A must be in 1..12");
    end
    if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
        $error("ascon_perm_sequencer: ROUNDS_B must be in 1..12");
    end

    localparam logic [3:0] START_A = start_index(ROUNDS_A);
    localparam logic [3:0] START_B = start_index(ROUNDS_B);

    type_seq_state state_q, state_d;
    type_perm_mode mode_q;
    type_perm_mode mode_in;
    logic          last_blk_q;

    logic          accept;
    logic [3:0]    start_idx;
    logic          cnt_enable;
    logic [3:0]    count;
    logic          cnt_first;
    logic          cnt_last;

    assign mode_in   = type_perm_mode'(mode_i);
    assign accept    = (state_q == ST_IDLE) && start_i && (mode_in != MODE_RSVD);
    assign start_idx = (mode_in == MODE_DATA) ? START_B : START_A;
    // Hold at LAST_ROUND once reached so the counter never wraps past 4'hB.
    assign cnt_enable = (state_q == ST_ROUND) && !cnt_last;

    ascon_round_counter u_round_counter (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .load_i      (accept),
        .start_idx_i (start_idx),
        .enable_i    (cnt_enable),
        .count_o     (count),
        .first_o     (cnt_first),
        .last_o      (cnt_last)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_INIT;
            last_blk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q     <= mode_in;
                last_blk_q <= last_blk_i;
            end
        end
    end

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d          = state_q;
        ready_o          = 1'b0;
        round_o          = 4'h0;
        data_sel_o       = 1'b0;
        en_reg_state_o   = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_o     = 1'b0;
        done_o           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (accept) begin
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                en_reg_state_o = 1'b1;
                round_o        = count;
                // Only the first INIT round loads the external state.
                data_sel_o     = !(cnt_first && (mode_q == MODE_INIT));
                en_xor_data_o  = cnt_first && (mode_q != MODE_INIT);
                en_xor_key_o   = cnt_first && (mode_q == MODE_FINAL);
                en_xor_key_end_o = cnt_last && (mode_q != MODE_DATA);
                en_xor_lsb_o   = cnt_last && (mode_q == MODE_DATA) && last_blk_q;
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ascon_perm_sequencer
// Scoreboard bench: each issued call pushes its expected per-cycle output
// vectors; a monitor pops and compares on every cycle the DUT is active
// (en_reg_state_o or done_o). Vector layout:
//   {ready, round[3:0], en_reg_state, data_sel, xor_data, xor_key,
//    xor_key_end, xor_lsb, done}
// -----------------------------------------------------------------------------
module tb_ascon_perm_sequencer;

    localparam logic [1:0] M_INIT  = 2'b00;
    localparam logic [1:0] M_DATA  = 2'b01;
    localparam logic [1:0] M_FINAL = 2'b10;
    localparam logic [1:0] M_RSVD  = 2'b11;

    localparam logic [11:0] VEC_IDLE = 12'h800;
    localparam logic [11:0] VEC_DONE = 12'h001;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [1:0] mode_i;
    logic       last_blk_i;
    logic       ready_o;
    logic [3:0] round_o;
    logic       data_sel_o;
    logic       en_reg_state_o;
    logic       en_xor_data_o;
    logic       en_xor_key_o;
    logic       en_xor_key_end_o;
    logic       en_xor_lsb_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    ascon_perm_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
        .clock_i          (clk),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .mode_i           (mode_i),
        .last_blk_i       (last_blk_i),
        .ready_o          (ready_o),
        .round_o          (round_o),
        .data_sel_o       (data_sel_o),
        .en_reg_state_o   (en_reg_state_o),
        .en_xor_data_o    (en_xor_data_o),
        .en_xor_key_o     (en_xor_key_o),
        .en_xor_key_end_o (en_xor_key_end_o),
        .en_xor_lsb_o     (en_xor_lsb_o),
        .done_o           (done_o)
    );

    function automatic logic [11:0] out_vec();
        return {ready_o, round_o, en_reg_state_o, data_sel_o, en_xor_data_o,
                en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o, done_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected vector for one round cycle, written from the phase table.
    function automatic logic [11:0] round_vec(input logic [1:0] mode, input logic last,
                                              input int n, input int r);
        logic first_r, last_r;
        logic sel, xd, xk, xke, xlsb;
        first_r = (r == 12 - n);
        last_r  = (r == 11);
        sel  = !(first_r && mode == M_INIT);
        xd   = first_r && (mode == M_DATA || mode == M_FINAL);
        xk   = first_r && (mode == M_FINAL);
        xke  = last_r && (mode == M_INIT || mode == M_FINAL);
        xlsb = last_r && (mode == M_DATA) && last;
        return {1'b0, 4'(r), 1'b1, sel, xd, xk, xke, xlsb, 1'b0};
    endfunction

    // Push the first `upto` rounds of a call; a full call also gets DONE.
    task automatic push_call(input logic [1:0] mode, input logic last, input int n, input int upto);
        for (int i = 0; i < upto; i++) exp_q.push_back(round_vec(mode, last, n, 12 - n + i));
        if (upto == n) exp_q.push_back(VEC_DONE);
    endtask

    // Count cycles from the accept edge to done_o, bounded.
    task automatic wait_done(input string name, input int n);
        int k = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (done_o) seen = 1;
        end
        check({name, "_done_latency"}, seen ? k : -1, n + 1);
    endtask

    // Full call: drive start for one edge, check latency, ready return and
    // that the scoreboard drained.
    task automatic run_call(input string name, input logic [1:0] mode, input logic last, input int n);
        check({name, "_ready_before"}, ready_o, 1);
        push_call(mode, last, n, n);
        start_i = 1'b1; mode_i = mode; last_blk_i = last;
        @(posedge clk); #1;
        start_i = 1'b0; last_blk_i = 1'b0;
        wait_done(name, n);
        @(negedge clk);
        check({name, "_ready_after"}, out_vec(), VEC_IDLE);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every active cycle against the scoreboard.
    always @(negedge clk) begin
        if (!reset_i && (en_reg_state_o || done_o)) begin
            check("monitor_expected_activity", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("monitor_vector", out_vec(), exp_q.pop_front());
        end
    end

    initial begin
        int dones;
        reset_i = 1'b1; start_i = 1'b0; mode_i = M_INIT; last_blk_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_vec(), VEC_IDLE);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("idle_after_reset", out_vec(), VEC_IDLE);
        @(posedge clk); #1;

        run_call("init",       M_INIT,  1'b0, 12);
        run_call("data_nolast", M_DATA, 1'b0, 6);
        run_call("data_last",  M_DATA,  1'b1, 6);
        run_call("final",      M_FINAL, 1'b0, 12);

        // start_i held through a DATA call: second accept only once idle again.
        push_call(M_DATA, 1'b0, 6, 6);
        push_call(M_DATA, 1'b0, 6, 6);
        start_i = 1'b1; mode_i = M_DATA;
        @(posedge clk); #1;
        wait_done("held_first", 6);
        @(negedge clk);
        check("held_ready_t8", out_vec(), VEC_IDLE);
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done("held_second", 6);
        @(negedge clk);
        check("held_ready_after", out_vec(), VEC_IDLE);
        check("held_queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;

        // Reset asserted during round 4 of INIT: no done, immediate idle.
        push_call(M_INIT, 1'b0, 12, 4);
        start_i = 1'b1; mode_i = M_INIT;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_i = 1'b1;
        @(negedge clk);
        check("midreset_round_before", round_o, 4);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("midreset_idle", out_vec(), VEC_IDLE);
        check("midreset_queue_drained", exp_q.size(), 0);
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("midreset_no_done", dones, 0);
        @(posedge clk); #1;

        // Reserved mode: start ignored, no activity.
        start_i = 1'b1; mode_i = M_RSVD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rsvd_stays_idle", out_vec(), VEC_IDLE);
        end
        @(posedge clk); #1;
        start_i = 1'b0; mode_i = M_INIT;

        // Reset and start in the same cycle: reset wins.
        reset_i = 1'b1; start_i = 1'b1; mode_i = M_DATA;
        @(posedge clk); #1;
        reset_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("reset_beats_start", out_vec(), VEC_IDLE);
        @(negedge clk);
        check("reset_beats_start_later", out_vec(), VEC_IDLE);
        @(posedge clk); #1;

        // A normal call still works afterwards.
        run_call("data_after", M_DATA, 1'b1, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
